// File: rtl/dm_pkg.sv
// Shared debug-module types for the system-bus-access engine.
// Error codes mirror the sbcs.sberror field encoding.
package dm_pkg;

    localparam int unsigned SbaMaxBusWidth = 64;

    typedef enum logic [2:0] {
        None    = 3'd0,
        Timeout = 3'd1,
        BadAddr = 3'd2,
        Align   = 3'd3,
        Size    = 3'd4,
        Other   = 3'd7
    } sberr_e;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite
    } sba_state_e;

    typedef struct packed {
        logic [2:0] sbversion;
        logic [5:0] zero0;
        logic       sbbusyerror;
        logic       sbbusy;
        logic       sbreadonaddr;
        logic [2:0] sbaccess;
        logic       sbautoincrement;
        logic       sbreadondata;
        logic [2:0] sberror;
        logic [6:0] sbasize;
        logic       sbaccess128;
        logic       sbaccess64;
        logic       sbaccess32;
        logic       sbaccess16;
        logic       sbaccess8;
    } sbcs_t;

endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane steering for SBA: enables, write replication, read extraction.
// Callers only present sizes that fit the bus and offsets aligned to the size.
module dm_sba_lane #(
    parameter int unsigned BusWidth = 32
) (
    input  logic [$clog2(BusWidth/8)-1:0] off_i,
    input  logic [2:0]                    size_i,
    input  logic [BusWidth-1:0]           wdata_i,
    input  logic [BusWidth-1:0]           rdata_i,
    output logic [BusWidth/8-1:0]         be_o,
    output logic [BusWidth-1:0]           wdata_o,
    output logic [BusWidth-1:0]           rdata_o
);

    localparam int NB = BusWidth / 8;

    int nbytes;
    int off;

    always_comb begin
        nbytes  = 1 << size_i;
        off     = int'(off_i);
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        for (int i = 0; i < NB; i++) begin
            be_o[i] = (i >= off) && (i < off + nbytes);
            wdata_o[8*i +: 8] = wdata_i[8*(i & (nbytes - 1)) +: 8];
            if ((i < nbytes) && (i + off < NB)) begin
                rdata_o[8*i +: 8] = rdata_i[8*(i + off) +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_sba_engine.sv
// System-bus-access master for the debug module: CSR triggers in,
// req/gnt/rvalid bus out, with lane steering and sticky error reporting.
module dm_sba_engine #(
    parameter int unsigned BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic [2:0]            sberror_o,
    output logic                  sbbusyerror_o,
    input  logic                  sberror_clr_i,
    input  logic                  sbbusyerror_clr_i,
    output logic                  req_o,
    output logic                  we_o,
    output logic [BusWidth-1:0]   addr_o,
    output logic [BusWidth-1:0]   wdata_o,
    output logic [BusWidth/8-1:0] be_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [BusWidth-1:0]   rdata_i,
    input  logic                  err_i
);

    import dm_pkg::*;

    localparam int unsigned OffW    = $clog2(BusWidth / 8);
    localparam logic [2:0]  MaxSize = 3'(OffW);

    sba_state_e            state_q, state_d;
    sberr_e                err_q, err_d;
    logic                  berr_q, berr_d;
    logic                  valid_q, valid_d;
    logic [BusWidth-1:0]   addr_q, addr_d;
    logic [BusWidth-1:0]   wdata_q, wdata_d;
    logic [BusWidth-1:0]   rdata_q, rdata_d;
    logic [BusWidth-1:0]   acc_addr_q, acc_addr_d;
    logic [BusWidth-1:0]   acc_wdata_q, acc_wdata_d;
    logic [2:0]            acc_size_q, acc_size_d;
    logic                  acc_inc_q, acc_inc_d;

    logic                  trig_wr, trig_rd, trig, idle;
    logic                  size_bad, align_bad;
    logic [BusWidth-1:0]   trig_addr, trig_wdata, incr;
    logic [BusWidth/8-1:0] lane_be;
    logic [BusWidth-1:0]   lane_wdata, lane_rdata;

    assign trig_wr    = sbdata_write_valid_i;
    assign trig_rd    = (sbaddress_write_valid_i & sbreadonaddr_i)
                      | (sbdata_read_valid_i & sbreadondata_i);
    assign trig       = trig_wr | trig_rd;
    assign idle       = (state_q == Idle);
    // A same-cycle address write is the address the access must use.
    assign trig_addr  = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    assign trig_wdata = sbdata_write_valid_i ? sbdata_i : wdata_q;
    assign size_bad   = sbaccess_i > MaxSize;
    assign align_bad  = |(trig_addr & ~({BusWidth{1'b1}} << sbaccess_i));
    assign incr       = BusWidth'(1) << acc_size_q;

    dm_sba_lane #(
        .BusWidth(BusWidth)
    ) u_lane (
        .off_i  (acc_addr_q[OffW-1:0]),
        .size_i (acc_size_q),
        .wdata_i(acc_wdata_q),
        .rdata_i(rdata_i),
        .be_o   (lane_be),
        .wdata_o(lane_wdata),
        .rdata_o(lane_rdata)
    );

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        berr_d      = berr_q;
        valid_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        acc_size_d  = acc_size_q;
        acc_inc_d   = acc_inc_q;
        if (sberror_clr_i)           err_d   = None;
        if (sbbusyerror_clr_i)       berr_d  = 1'b0;
        if (sbaddress_write_valid_i) addr_d  = sbaddress_i;
        if (sbdata_write_valid_i)    wdata_d = sbdata_i;
        if (trig && !idle)           berr_d  = 1'b1;
        unique case (state_q)
            Idle: begin
                if (trig && (err_q == None)) begin
                    if (size_bad) begin
                        err_d = Size;
                    end else if (align_bad) begin
                        err_d = Align;
                    end else begin
                        acc_addr_d  = trig_addr;
                        acc_wdata_d = trig_wdata;
                        acc_size_d  = sbaccess_i;
                        acc_inc_d   = sbautoincrement_i;
                        state_d     = trig_wr ? Write : Read;
                    end
                end
            end
            Read:  if (gnt_i) state_d = WaitRead;
            Write: if (gnt_i) state_d = WaitWrite;
            WaitRead, WaitWrite: begin
                if (rvalid_i) begin
                    state_d = Idle;
                    if (err_i) begin
                        err_d = BadAddr;
                    end else begin
                        if (state_q == WaitRead) begin
                            rdata_d = lane_rdata;
                            valid_d = 1'b1;
                        end
                        if (acc_inc_q && !sbaddress_write_valid_i) begin
                            addr_d = acc_addr_q + incr;
                        end
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            err_q       <= None;
            berr_q      <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            acc_size_q  <= '0;
            acc_inc_q   <= 1'b0;
        end else if (!dmactive_i) begin
            state_q     <= Idle;
            err_q       <= None;
            berr_q      <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            acc_size_q  <= '0;
            acc_inc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            berr_q      <= berr_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            acc_size_q  <= acc_size_d;
            acc_inc_q   <= acc_inc_d;
        end
    end

    assign sbaddress_o    = addr_q;
    assign sbdata_o       = rdata_q;
    assign sbdata_valid_o = valid_q;
    assign sbbusy_o       = !idle;
    assign sberror_o      = err_q;
    assign sbbusyerror_o  = berr_q;
    assign req_o          = (state_q == Read) || (state_q == Write);
    assign we_o           = (state_q == Write);
    assign addr_o         = req_o ? {acc_addr_q[BusWidth-1:OffW], {OffW{1'b0}}} : '0;
    assign be_o           = req_o ? lane_be : '0;
    assign wdata_o        = req_o ? lane_wdata : '0;

endmodule

// File: tb/tb_dm_sba_engine.sv
// Scoreboard bench for dm_sba_engine at BusWidth 32 and 64; only the
// instance selected by sel is active, the other is held inactive.
module tb_dm_sba_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit          sel = 1'b0;
    logic        dmactive = 1'b1;
    logic [63:0] sbaddress = '0, sbdata = '0, rdata = '0;
    logic        aw = 0, dw = 0, dr = 0, roa = 0, rod = 0, inc = 0;
    logic [2:0]  acc = '0;
    logic        eclr = 0, bclr = 0, gnt = 0, rvalid = 0, err = 0;

    logic [31:0] sba32, sbd32, ad32, wd32;
    logic [3:0]  be32;
    logic [2:0]  se32, se64;
    logic        v32, b32, be_32, rq32, we32;
    logic [63:0] sba64, sbd64, ad64, wd64;
    logic [7:0]  be64;
    logic        v64, b64, be_64, rq64, we64;

    dm_sba_engine #(.BusWidth(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive && !sel),
        .sbaddress_i(sbaddress[31:0]), .sbaddress_write_valid_i(aw),
        .sbdata_i(sbdata[31:0]), .sbdata_write_valid_i(dw),
        .sbdata_read_valid_i(dr), .sbreadonaddr_i(roa),
        .sbreadondata_i(rod), .sbautoincrement_i(inc), .sbaccess_i(acc),
        .sbaddress_o(sba32), .sbdata_o(sbd32), .sbdata_valid_o(v32),
        .sbbusy_o(b32), .sberror_o(se32), .sbbusyerror_o(be_32),
        .sberror_clr_i(eclr), .sbbusyerror_clr_i(bclr),
        .req_o(rq32), .we_o(we32), .addr_o(ad32), .wdata_o(wd32),
        .be_o(be32), .gnt_i(gnt), .rvalid_i(rvalid),
        .rdata_i(rdata[31:0]), .err_i(err)
    );

    dm_sba_engine #(.BusWidth(64)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive && sel),
        .sbaddress_i(sbaddress), .sbaddress_write_valid_i(aw),
        .sbdata_i(sbdata), .sbdata_write_valid_i(dw),
        .sbdata_read_valid_i(dr), .sbreadonaddr_i(roa),
        .sbreadondata_i(rod), .sbautoincrement_i(inc), .sbaccess_i(acc),
        .sbaddress_o(sba64), .sbdata_o(sbd64), .sbdata_valid_o(v64),
        .sbbusy_o(b64), .sberror_o(se64), .sbbusyerror_o(be_64),
        .sberror_clr_i(eclr), .sbbusyerror_clr_i(bclr),
        .req_o(rq64), .we_o(we64), .addr_o(ad64), .wdata_o(wd64),
        .be_o(be64), .gnt_i(gnt), .rvalid_i(rvalid),
        .rdata_i(rdata), .err_i(err)
    );

    logic [63:0] o_sba, o_sbd, o_addr, o_wd;
    logic [7:0]  o_be;
    logic [2:0]  o_serr;
    logic        o_v, o_busy, o_berr, o_req, o_we;
    assign o_sba  = sel ? sba64 : {32'b0, sba32};
    assign o_sbd  = sel ? sbd64 : {32'b0, sbd32};
    assign o_addr = sel ? ad64 : {32'b0, ad32};
    assign o_wd   = sel ? wd64 : {32'b0, wd32};
    assign o_be   = sel ? be64 : {4'b0, be32};
    assign o_serr = sel ? se64 : se32;
    assign o_v    = sel ? v64 : v32;
    assign o_busy = sel ? b64 : b32;
    assign o_berr = sel ? be_64 : be_32;
    assign o_req  = sel ? rq64 : rq32;
    assign o_we   = sel ? we64 : we32;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s actual=%h required=none", nm, act);
    endtask

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wd;
    } bus_t;

    bus_t        bq[$];
    logic [63:0] rq[$];
    bus_t        pv;
    bit          ph = 1'b0;

    // Monitor: checks every granted request, hold stability and read returns.
    always @(negedge clk) begin
        if (o_req && ph) begin
            chk("hold_addr", o_addr, pv.addr);
            chk("hold_be", {56'b0, o_be}, {56'b0, pv.be});
            chk("hold_we", {63'b0, o_we}, {63'b0, pv.we});
            chk("hold_wdata", o_wd, pv.wd);
        end
        if (o_req && gnt) begin
            if (bq.size() == 0) begin
                fail("bus_unexpected", o_addr);
            end else begin
                bus_t e;
                e = bq.pop_front();
                chk("bus_we", {63'b0, o_we}, {63'b0, e.we});
                chk("bus_addr", o_addr, e.addr);
                chk("bus_be", {56'b0, o_be}, {56'b0, e.be});
                if (e.we) chk("bus_wdata", o_wd, e.wd);
            end
        end
        ph = o_req && !gnt;
        pv.addr = o_addr;
        pv.be = o_be;
        pv.we = o_we;
        pv.wd = o_wd;
        if (o_v) begin
            if (rq.size() == 0) fail("rdata_unexpected", o_sbd);
            else chk("rdata", o_sbd, rq.pop_front());
        end
    end

    logic [63:0] m_addr = '0, m_data = '0;
    int          m_err = 0;
    bit          m_berr = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_csr(input string tag);
        chk({tag, "_busy"}, {63'b0, o_busy}, 64'd0);
        chk({tag, "_sbaddress"}, o_sba, m_addr);
        chk({tag, "_sbdata"}, o_sbd, m_data);
        chk({tag, "_sberror"}, {61'b0, o_serr}, 64'(m_err));
        chk({tag, "_busyerror"}, {63'b0, o_berr}, {63'b0, m_berr});
    endtask

    task automatic dm_restart(input bit s);
        dmactive = 1'b0;
        cyc();
        sel = s;
        cyc();
        dmactive = 1'b1;
        m_addr = '0;
        m_data = '0;
        m_err = 0;
        m_berr = 1'b0;
        cyc();
    endtask

    task automatic clear_errs();
        eclr = 1'b1;
        bclr = 1'b1;
        cyc();
        eclr = 1'b0;
        bclr = 1'b0;
        m_err = 0;
        m_berr = 1'b0;
        chk("clr_sberror", {61'b0, o_serr}, 64'd0);
        chk("clr_busyerror", {63'b0, o_berr}, 64'd0);
    endtask

    // kind 0: sbaddress+sbdata write, 1: read on address write, 2: read on data read
    task automatic access(input int kind, input logic [63:0] a, input logic [63:0] d,
                          input int sz, input bit ainc, input int gd, input int rdl,
                          input bit berr, input logic [63:0] rd, input bit poke);
        int          nb = sel ? 8 : 4;
        int          lg = sel ? 3 : 2;
        logic [63:0] am = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        logic [63:0] ta, mask, val, rep;
        int          n, off;
        bit          go;
        bus_t        e;
        a = a & am;
        d = d & am;
        rd = rd & am;
        ta = (kind == 2) ? m_addr : a;
        if (kind != 2) m_addr = a;
        go = 1'b0;
        n = 1 << sz;
        if (m_err != 0) go = 1'b0;
        else if (sz > lg) m_err = 4;
        else if ((ta % 64'(n)) != 0) m_err = 3;
        else go = 1'b1;
        acc = 3'(sz);
        inc = ainc;
        roa = (kind == 1);
        rod = (kind == 2);
        sbaddress = a;
        sbdata = d;
        aw = (kind != 2);
        dw = (kind == 0);
        dr = (kind == 2);
        off = int'(ta % 64'(nb));
        mask = (n >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 1);
        if (go) begin
            val = d & mask;
            rep = '0;
            for (int c = 0; c < nb / n; c++) rep = rep | (val << (8 * n * c));
            e.we = (kind == 0);
            e.addr = ta - 64'(off);
            e.be = 8'(((1 << n) - 1) << off);
            e.wd = rep;
            bq.push_back(e);
        end
        cyc();
        aw = 1'b0;
        dw = 1'b0;
        dr = 1'b0;
        if (!go) begin
            chk("no_req", {63'b0, o_req}, 64'd0);
            cyc();
            chk("no_req_later", {63'b0, o_req}, 64'd0);
            chk("pre_sberror", {61'b0, o_serr}, 64'(m_err));
            return;
        end
        chk("req_next_cycle", {63'b0, o_req}, 64'd1);
        for (int i = 0; i < gd; i++) begin
            dw = poke && (i == 1);
            if (dw) sbdata = {$urandom, $urandom};
            cyc();
        end
        dw = 1'b0;
        if (poke && gd >= 2) m_berr = 1'b1;
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        chk("wait_busy", {63'b0, o_busy}, 64'd1);
        chk("wait_no_req", {63'b0, o_req}, 64'd0);
        repeat (rdl) cyc();
        if (berr) begin
            m_err = 2;
        end else begin
            if (kind != 0) begin
                m_data = (rd >> (8 * off)) & mask;
                rq.push_back(m_data);
            end
            if (ainc) m_addr = (ta + 64'(n)) & am;
        end
        rvalid = 1'b1;
        err = berr;
        rdata = rd;
        cyc();
        rvalid = 1'b0;
        err = 1'b0;
        check_csr("done");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        cyc();
        cyc();
        chk("rst_req", {63'b0, o_req}, 64'd0);
        chk("rst_addr", o_addr, 64'd0);
        check_csr("rst");
        rst_n = 1'b1;
        cyc();

        access(1, 64'h1000, 0, 2, 0, 0, 0, 0, 64'hDEADBEEF, 0);

        dm_restart(1'b1);
        access(0, 64'h2003, 64'hA5, 0, 0, 1, 1, 0, 0, 0);
        access(1, 64'h2003, 0, 0, 0, 0, 0, 0, 64'h11223344_55667788, 0);
        chk("byte_read", o_sbd, 64'h55);

        dm_restart(1'b0);
        access(1, 64'hFFFF_FFFC, 0, 2, 1, 0, 0, 0, 64'h0BAD_F00D, 0);
        chk("wrap_addr", o_sba, 64'h0);
        access(2, 0, 0, 2, 1, 0, 1, 0, 64'h1234_5678, 0);

        access(1, 64'h1002, 0, 2, 0, 0, 0, 0, 0, 0);
        chk("misalign_err", {61'b0, o_serr}, 64'd3);
        clear_errs();
        access(1, 64'h1000, 0, 3, 0, 0, 0, 0, 0, 0);
        chk("size_err", {61'b0, o_serr}, 64'd4);
        clear_errs();

        access(0, 64'h3000, 64'h600D_CAFE, 2, 1, 5, 0, 1, 0, 1);
        chk("busy_err", {63'b0, o_berr}, 64'd1);
        chk("bad_addr_err", {61'b0, o_serr}, 64'd2);
        clear_errs();

        acc = 3'd2;
        roa = 1'b1;
        rod = 1'b0;
        sbaddress = 64'h40;
        aw = 1'b1;
        bq.push_back('{1'b0, 64'h40, 8'h0F, 64'h0});
        cyc();
        aw = 1'b0;
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        chk("abort_busy_before", {63'b0, o_busy}, 64'd1);
        dmactive = 1'b0;
        cyc();
        dmactive = 1'b1;
        m_addr = '0;
        m_data = '0;
        chk("abort_req", {63'b0, o_req}, 64'd0);
        check_csr("abort");
        rvalid = 1'b1;
        rdata = 64'hFFFF_FFFF;
        cyc();
        rvalid = 1'b0;
        cyc();
        check_csr("late_rvalid");

        for (int s = 0; s < 2; s++) begin
            dm_restart(s[0]);
            for (int k = 0; k < 40; k++) begin
                int          kind, sz, lg;
                logic [63:0] a;
                lg = s ? 3 : 2;
                kind = $urandom % 3;
                sz = $urandom % (lg + 2);
                a = {$urandom, $urandom};
                if ($urandom % 4 != 0) a = a & ~((64'd1 << sz) - 1);
                access(kind, a, {$urandom, $urandom}, sz, $urandom % 2,
                       $urandom % 4, $urandom % 3, ($urandom % 8) == 0,
                       {$urandom, $urandom}, ($urandom % 2) == 1);
                if ((m_err != 0 || m_berr) && ($urandom % 2 == 0)) clear_errs();
            end
        end

        repeat (3) cyc();
        chk("bus_queue_drained", 64'(bq.size()), 64'd0);
        chk("read_queue_drained", 64'(rq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_sba_engine.md
# dm_sba_engine

Parametrised system-bus-access (SBA) master for the debug module. It executes debugger-initiated reads and writes from the `sbcs`/`sbaddress`/`sbdata` CSRs on a req/gnt/rvalid bus of configurable width. It adds the following to the current SBA path:
- BusWidth of 32 or 64;
- sub-word byte-lane steering;
- alignment and size checking;
- bus-error reporting;
- sbbusyerror detection.

It sits between the DM CSR block and the SoC interconnect port.

## Interface
- BusWidth, 32: address and data width; only 32 or 64 are legal.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  DM active; low aborts and clears everything
- sbaddress_i  in  BusWidth  address written by debugger
- sbaddress_write_valid_i  in  1  debugger wrote sbaddress0
- sbdata_i  in  BusWidth  data written by debugger
- sbdata_write_valid_i  in  1  debugger wrote sbdata0
- sbdata_read_valid_i  in  1  debugger read sbdata0
- sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  in  1 each  sbcs mode bits
- sbaccess_i  in  3  log2 of access size in bytes
- sbaddress_o  out  BusWidth  current (possibly incremented) address
- sbdata_o  out  BusWidth  last read data, right-aligned, zero-extended
- sbdata_valid_o  out  1  one-cycle pulse when sbdata_o updated
- sbbusy_o  out  1  access in progress
- sberror_o  out  3  sticky error code (`dm::sberr_e`)
- sbbusyerror_o  out  1  sticky: access started while busy
- sberror_clr_i, sbbusyerror_clr_i  in  1 each  W1C from CSR block
- req_o  out  1  bus request
- we_o  out  1  bus write
- addr_o  out  BusWidth  bus address, aligned to BusWidth/8
- wdata_o  out  BusWidth  byte-lane replicated write data
- be_o  out  BusWidth/8  byte enables
- gnt_i  in  1  bus grant
- rvalid_i  in  1  response valid (reads and writes)
- rdata_i  in  BusWidth  read data
- err_i  in  1  response error, qualified by rvalid_i

## Operation
- FSM uses `dm::sba_state_e`:
  - Idle: trigger sources:
    - sbaddress write with sbreadonaddr -> Read;
    - sbdata read with sbreadondata -> Read;
    - sbdata write -> Write.
  - Read/Write: req_o=1; stays until gnt_i, then WaitRead/WaitWrite.
  - WaitRead/WaitWrite: on rvalid_i -> Idle.
- sbbusy_o = (state != Idle).
- Trigger while not Idle, or while sberror_o != 0: no access is started. A trigger while busy sets sbbusyerror_o. sbaddress/sbdata writes while busy are still latched.
- Pre-checks at trigger; on failure the FSM stays Idle, sets sberror_o and issues no bus request:
  - size check: sbaccess_i > log2(BusWidth/8) -> 4 (unsupported size);
  - alignment check: address not aligned to 2^sbaccess -> 3 (alignment).
- Lane handling:
  - addr_o = address with the low log2(BusWidth/8) bits cleared;
  - be_o = ((1<<2^sbaccess)-1) << addr[low];
  - wdata_o = sbdata low 2^sbaccess bytes replicated across the bus;
  - read data is shifted right by addr[low]*8 and masked to the size.
- Completion:
  - read rvalid_i & !err_i: sbdata_o updated, sbdata_valid_o pulses.
  - rvalid_i & err_i: sberror_o=2 (bad address), sbdata_o unchanged, no increment.
  - On success with sbautoincrement_i: sbaddress_o += 2^sbaccess, modulo 2^BusWidth (wraps to 0).
- Sticky errors:
  - sberror_o and sbbusyerror_o persist until their clr input or until dmactive_i low.
  - Set and clr in the same cycle: set wins.

## Timing
- Reset (rst_ni low) or dmactive_i low: state Idle and all outputs 0. req_o drops the next cycle even mid-handshake; a late rvalid_i is ignored in Idle.
- Trigger in cycle N -> req_o high in N+1.
- gnt_i at cycle M -> WaitX at M+1.
- rvalid_i at cycle K -> sbdata_o/sbdata_valid_o/sbaddress_o update and sbbusy_o low at K+1.
- Minimum access: 3 cycles with gnt and rvalid both one cycle after req.
- addr_o, we_o, be_o and wdata_o are held stable while req_o && !gnt_i.
- Simultaneous sbaddress write and sbdata write in Idle: the write takes priority and uses the new address.

## Structure
- dm_pkg gets:
  - `sberr_e` enum: None=0, Timeout=1, BadAddr=2, Align=3, Size=4, Other=7;
  - a `SbaMaxBusWidth` localparam;
  - the existing `sba_state_e` and `sbcs_t` are reused.
- One sub-module, `dm_sba_lane`: a combinational be/wdata replication and rdata extraction helper, parametrised by BusWidth.

## Test plan
- BusWidth=32, sbaccess=2, sbaddress=0x1000 with readonaddr, rdata=0xDEADBEEF -> req at N+1; after rvalid, sbdata_o=0xDEADBEEF and sbbusy_o=0.
- BusWidth=64, sbaccess=0, write sbdata=0xA5 to addr 0x2003 -> addr_o=0x2000, be_o=0x08, wdata_o=0xA5A5A5A5A5A5A5A5; then a read of 0x2003 with rdata 0x11223344_55667788 -> sbdata_o=0x55.
- Autoincrement: sbaccess=2, start 0xFFFFFFFC, BusWidth=32, readondata -> first read uses 0xFFFFFFFC and sbaddress_o wraps to 0x0.
- Misaligned sbaccess=2 at 0x1002 -> sberror_o=3, no req_o; sbaccess=3 on BusWidth=32 -> sberror_o=4. Both clear with sberror_clr_i.
- gnt_i withheld 5 cycles, then sbdata write while busy -> sbbusyerror_o=1; bus signals are stable throughout; rvalid_i with err_i -> sberror_o=2.
- dmactive_i low in WaitRead -> Idle and outputs 0 next cycle; a later rvalid_i causes no sbdata_o update.
